// File: rtl/freq_buffer_pkg.sv
// Shared types, grant encodings and address-width helper for the ping-pong frequency buffer controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package freq_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } rd_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_RD0  = 2'b01;
  localparam logic [1:0] GNT_RD1  = 2'b10;

  // Address width for a frame of the given depth; never narrower than one bit.
  function automatic int addr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/freq_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, on contention the reader not served last wins.
// Latency: pick is combinational; the priority register moves on the edge where upd is high.
// Backpressure: none; the caller decides when a pick is taken and when priority is updated.
module freq_rr_arb2
  import freq_buffer_pkg::*;
(
  input  logic       sink_clk,
  input  logic       sink_reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] win
);

  logic last_idx;

  // Remember which reader held the last grant; reset favours reader 0.
  always_ff @(posedge sink_clk or posedge sink_reset) begin
    if (sink_reset) begin
      last_idx <= 1'b1;
    end else if (upd) begin
      last_idx <= upd_idx;
    end
  end

  // Pick a winner from the current requests.
  always_comb begin
    win = GNT_NONE;
    case (req)
      2'b01:   win = GNT_RD0;
      2'b10:   win = GNT_RD1;
      2'b11:   win = last_idx ? GNT_RD0 : GNT_RD1;
      default: win = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/freq_buffer_ctrl.sv
// Ping-pong frame buffer sequencer: write addressing, bank swap, round-robin reader grant, read stream.
// Latency: write strobe/address are same-cycle; grant one cycle after request; data flags RD_LAT after rd_en.
// Backpressure: rd_ready stalls the read address; a frame finishing while one is pending is dropped (overflow).
module freq_buffer_ctrl
  import freq_buffer_pkg::*;
#(
  parameter  int TOT_SIZE = 1024,
  parameter  int RD_LAT   = 2,
  localparam int AW       = addr_width(TOT_SIZE)
) (
  input  logic          sink_clk,
  input  logic          sink_reset,
  input  logic          sink_sop,
  input  logic          sink_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_bank,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  input  logic          rd_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          rd_bank,
  output logic          rd_dvalid,
  output logic          rd_dlast,
  output logic          frame_ready,
  output logic          overflow,
  output logic          short_frame
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(TOT_SIZE - 1);

  logic [AW-1:0]     wr_ptr;
  logic              armed;
  logic              wr_done;
  rd_state_t         state;
  logic              gnt_live;
  logic              abort;
  logic              release_rd;
  logic [1:0]        arb_win;
  logic [RD_LAT-1:0] dv_pipe;
  logic [RD_LAT-1:0] dl_pipe;

  // Write strobe: sop always opens a frame at entry 0, other beats need an open frame.
  always_comb begin
    wr_en   = ~sink_reset & sink_valid & (sink_sop | armed);
    wr_addr = sink_sop ? '0 : wr_ptr;
    wr_done = wr_en & ~sink_sop & (wr_ptr == LAST_ADDR);
  end

  // Read-side handshake terms; a dropped request while reading abandons the pass.
  always_comb begin
    gnt_live   = |(req & gnt);
    rd_en      = (state == READ) & rd_ready & gnt_live;
    abort      = (state == READ) & ~gnt_live;
    release_rd = (state == DONE);
  end

  // Write pointer and frame tracking; a second sop mid-frame throws the partial frame away.
  always_ff @(posedge sink_clk or posedge sink_reset) begin
    if (sink_reset) begin
      armed       <= 1'b0;
      wr_ptr      <= '0;
      short_frame <= 1'b0;
    end else begin
      short_frame <= sink_valid & sink_sop & armed & (wr_ptr != '0);
      if (sink_valid & sink_sop) begin
        armed  <= 1'b1;
        wr_ptr <= AW'(1);
      end else if (wr_done) begin
        armed  <= 1'b0;
        wr_ptr <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Bank swap on frame completion; a reader releasing its frame in the same cycle frees the slot.
  always_ff @(posedge sink_clk or posedge sink_reset) begin
    if (sink_reset) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= wr_done & frame_ready & ~release_rd;
      if (wr_done & (~frame_ready | release_rd)) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_ready <= 1'b1;
      end else if (release_rd) begin
        frame_ready <= 1'b0;
      end
    end
  end

  // Read sequencer: grant, stream the frame, release; an abort keeps the frame for the next grant.
  always_ff @(posedge sink_clk or posedge sink_reset) begin
    if (sink_reset) begin
      state   <= IDLE;
      gnt     <= GNT_NONE;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_ready & (|req)) begin
            gnt     <= arb_win;
            rd_addr <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (abort) begin
            gnt     <= GNT_NONE;
            rd_addr <= '0;
            state   <= IDLE;
          end else if (rd_en) begin
            // Address wraps to 0 after the last entry since the frame depth is a power of two.
            rd_addr <= rd_addr + 1'b1;
            if (rd_addr == LAST_ADDR) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          gnt   <= GNT_NONE;
          state <= IDLE;
        end
        default: begin
          gnt   <= GNT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  // Model the buffer read latency; reads already issued still emerge after an abort.
  always_ff @(posedge sink_clk or posedge sink_reset) begin
    if (sink_reset) begin
      dv_pipe <= '0;
      dl_pipe <= '0;
    end else begin
      dv_pipe[0] <= rd_en;
      dl_pipe[0] <= rd_en & (rd_addr == LAST_ADDR);
      for (int i = 1; i < RD_LAT; i++) begin
        dv_pipe[i] <= dv_pipe[i-1];
        dl_pipe[i] <= dl_pipe[i-1];
      end
    end
  end

  assign rd_dvalid = dv_pipe[RD_LAT-1];
  assign rd_dlast  = dl_pipe[RD_LAT-1];

  freq_rr_arb2 u_arb (
    .sink_clk   (sink_clk),
    .sink_reset (sink_reset),
    .req        (req),
    .upd        (release_rd | abort),
    .upd_idx    (gnt[1]),
    .win        (arb_win)
  );

  // The bank being filled must never be the one a reader may be draining.
  a_bank_split: assert property (@(posedge sink_clk) disable iff (sink_reset)
    frame_ready |-> (wr_bank != rd_bank));
  a_gnt_onehot: assert property (@(posedge sink_clk) disable iff (sink_reset)
    $onehot0(gnt));
  a_rd_in_read: assert property (@(posedge sink_clk) disable iff (sink_reset)
    rd_en |-> (state == READ));

endmodule

// File: tb/tb_freq_buffer_ctrl.sv
module tb_freq_buffer_ctrl;

  localparam int N      = 8;
  localparam int RD_LAT = 2;

  logic       sink_clk;
  logic       sink_reset;
  logic       sink_sop;
  logic       sink_valid;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       wr_bank;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_ready;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic       rd_bank;
  logic       rd_dvalid;
  logic       rd_dlast;
  logic       frame_ready;
  logic       overflow;
  logic       short_frame;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int   due;
    logic last;
  } sb_t;
  sb_t sb_q[$];

  freq_buffer_ctrl #(.TOT_SIZE(N), .RD_LAT(RD_LAT)) dut (
    .sink_clk    (sink_clk),
    .sink_reset  (sink_reset),
    .sink_sop    (sink_sop),
    .sink_valid  (sink_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_bank     (wr_bank),
    .req         (req),
    .gnt         (gnt),
    .rd_ready    (rd_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_bank     (rd_bank),
    .rd_dvalid   (rd_dvalid),
    .rd_dlast    (rd_dlast),
    .frame_ready (frame_ready),
    .overflow    (overflow),
    .short_frame (short_frame)
  );

  initial sink_clk = 1'b0;
  always #5 sink_clk = ~sink_clk;

  always @(posedge sink_clk) cyc++;

  // Scoreboard side: every read issued is expected back on the data flags RD_LAT cycles later.
  always @(negedge sink_clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      checks++;
      if (rd_dvalid !== 1'b1 || rd_dlast !== sb_q[0].last) begin
        errors++;
        $display("FAIL rd_pipe cyc=%0d dvalid=%b dlast=%b expected dvalid=1 dlast=%b",
                 cyc, rd_dvalid, rd_dlast, sb_q[0].last);
      end
      void'(sb_q.pop_front());
    end else if (rd_dvalid !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rd_pipe_extra cyc=%0d dvalid=%b expected 0", cyc, rd_dvalid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sink_clk);
    #1;
  endtask

  task automatic tick_idle();
    tick();
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    @(negedge sink_clk);
  endtask

  task automatic push_read(input int addr);
    sb_t e;
    e.due  = cyc + RD_LAT;
    e.last = (addr == N - 1);
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    sink_reset = 1'b1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    req        = 2'b00;
    rd_ready   = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge sink_clk);
    #1 sink_reset = 1'b0;
  endtask

  task automatic write_beats(input int n, input bit with_sop, input int start, input logic exp_bank);
    for (int i = 0; i < n; i++) begin
      tick();
      sink_valid = 1'b1;
      sink_sop   = with_sop && (i == 0);
      @(negedge sink_clk);
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'(start + i) || wr_bank !== exp_bank) begin
        errors++;
        $display("FAIL write_beat en=%b addr=%0d bank=%b expected en=1 addr=%0d bank=%b",
                 wr_en, wr_addr, wr_bank, start + i, exp_bank);
      end
    end
  endtask

  task automatic read_frame(input logic [1:0] r, input bit toggle, input logic [1:0] exp_gnt,
                            input logic exp_fr_after);
    int addr;
    int cnt;
    tick();
    req      = r;
    rd_ready = 1'b0;
    @(negedge sink_clk);
    checks++;
    if (gnt !== 2'b00 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_idle gnt=%b fr=%b expected gnt=00 fr=1", gnt, frame_ready);
    end
    addr = 0;
    cnt  = 0;
    while (addr < N && cnt < 64) begin
      tick();
      rd_ready = toggle ? cnt[0] : 1'b1;
      @(negedge sink_clk);
      checks++;
      if (gnt !== exp_gnt || rd_en !== rd_ready || (rd_ready && rd_addr !== 3'(addr))) begin
        errors++;
        $display("FAIL read_beat gnt=%b rd_en=%b addr=%0d expected gnt=%b rd_en=%b addr=%0d",
                 gnt, rd_en, rd_addr, exp_gnt, rd_ready, addr);
      end
      if (rd_ready) begin
        push_read(addr);
        addr++;
      end
      cnt++;
    end
    checks++;
    if (cnt !== (toggle ? 2 * N : N)) begin
      errors++;
      $display("FAIL read_cycles got=%0d expected=%0d", cnt, toggle ? 2 * N : N);
    end
    tick();
    rd_ready = 1'b0;
    @(negedge sink_clk);
    checks++;
    if (gnt !== exp_gnt || rd_en !== 1'b0 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done gnt=%b rd_en=%b fr=%b expected gnt=%b rd_en=0 fr=1",
               gnt, rd_en, frame_ready, exp_gnt);
    end
    tick();
    req = 2'b00;
    @(negedge sink_clk);
    checks++;
    if (gnt !== 2'b00 || frame_ready !== exp_fr_after) begin
      errors++;
      $display("FAIL read_release gnt=%b fr=%b expected gnt=00 fr=%b", gnt, frame_ready, exp_fr_after);
    end
    repeat (2) tick_idle();
  endtask

  task automatic test_reset();
    sink_reset = 1'b1;
    sink_valid = 1'b1;
    sink_sop   = 1'b1;
    req        = 2'b11;
    rd_ready   = 1'b1;
    #23;
    checks++;
    if ({wr_en, gnt, rd_en, frame_ready, wr_bank, rd_bank, overflow, short_frame, rd_dvalid, rd_dlast}
        !== 11'b0_00_0_0_0_1_0_0_0_0 || wr_addr !== 3'd0 || rd_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_state wr_en=%b gnt=%b rd_en=%b fr=%b wb=%b rb=%b ov=%b sf=%b dv=%b dl=%b wa=%0d ra=%0d expected rb=1 rest 0",
               wr_en, gnt, rd_en, frame_ready, wr_bank, rd_bank, overflow, short_frame,
               rd_dvalid, rd_dlast, wr_addr, rd_addr);
    end
    do_reset();
    @(negedge sink_clk);
    checks++;
    if (wr_bank !== 1'b0 || rd_bank !== 1'b1 || frame_ready !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL reset_release wb=%b rb=%b fr=%b gnt=%b expected 0 1 0 00",
               wr_bank, rd_bank, frame_ready, gnt);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    tick();
    sink_valid = 1'b1;
    sink_sop   = 1'b0;
    @(negedge sink_clk);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL valid_without_sop wr_en=%b expected 0", wr_en);
    end
    write_beats(N, 1'b1, 0, 1'b0);
    tick_idle();
    checks++;
    if ({wr_bank, rd_bank, frame_ready, overflow} !== 4'b1010) begin
      errors++;
      $display("FAIL frame_swap wb/rb/fr/ov=%b expected 1010", {wr_bank, rd_bank, frame_ready, overflow});
    end
    read_frame(2'b01, 1'b0, 2'b01, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01;
    exp_g[1] = 2'b10;
    exp_g[2] = 2'b01;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      write_beats(N, 1'b1, 0, 1'(f % 2));
      tick_idle();
      checks++;
      if (rd_bank !== 1'(f % 2) || wr_bank !== 1'((f + 1) % 2) || frame_ready !== 1'b1) begin
        errors++;
        $display("FAIL rr_banks frame=%0d rb=%b wb=%b fr=%b expected rb=%0d wb=%0d fr=1",
                 f, rd_bank, wr_bank, frame_ready, f % 2, (f + 1) % 2);
      end
      read_frame(2'b11, 1'b1, exp_g[f], 1'b0);
    end
  endtask

  task automatic test_abort();
    do_reset();
    write_beats(N, 1'b1, 0, 1'b0);
    tick_idle();
    tick();
    req      = 2'b01;
    rd_ready = 1'b1;
    @(negedge sink_clk);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge sink_clk);
      checks++;
      if (gnt !== 2'b01 || rd_en !== 1'b1 || rd_addr !== 3'(k)) begin
        errors++;
        $display("FAIL abort_pre gnt=%b rd_en=%b addr=%0d expected 01 1 %0d", gnt, rd_en, rd_addr, k);
      end
      push_read(k);
    end
    tick();
    req = 2'b00;
    @(negedge sink_clk);
    checks++;
    if (rd_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_rd_en got=%b expected 0", rd_en);
    end
    tick();
    rd_ready = 1'b0;
    @(negedge sink_clk);
    checks++;
    if (gnt !== 2'b00 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_retain gnt=%b fr=%b expected gnt=00 fr=1", gnt, frame_ready);
    end
    read_frame(2'b11, 1'b0, 2'b10, 1'b0);
  endtask

  task automatic test_overflow_swap();
    do_reset();
    write_beats(N, 1'b1, 0, 1'b0);
    write_beats(N, 1'b1, 0, 1'b1);
    tick_idle();
    checks++;
    if (overflow !== 1'b1 || wr_bank !== 1'b1 || rd_bank !== 1'b0 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse ov=%b wb=%b rb=%b fr=%b expected 1 1 0 1",
               overflow, wr_bank, rd_bank, frame_ready);
    end
    tick_idle();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_width ov=%b expected 0", overflow);
    end
    for (int t = 0; t <= 10; t++) begin
      tick();
      req        = (t <= 9) ? 2'b01 : 2'b00;
      rd_ready   = 1'b1;
      sink_valid = (t >= 2 && t <= 9);
      sink_sop   = (t == 2);
      @(negedge sink_clk);
      if (t >= 1 && t <= 8) begin
        checks++;
        if (gnt !== 2'b01 || rd_en !== 1'b1 || rd_addr !== 3'(t - 1)) begin
          errors++;
          $display("FAIL swap_read t=%0d gnt=%b rd_en=%b addr=%0d expected 01 1 %0d",
                   t, gnt, rd_en, rd_addr, t - 1);
        end
        push_read(t - 1);
      end
      if (t >= 2 && t <= 9) begin
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 3'(t - 2) || wr_bank !== 1'b1) begin
          errors++;
          $display("FAIL swap_write t=%0d en=%b addr=%0d bank=%b expected 1 %0d 1",
                   t, wr_en, wr_addr, wr_bank, t - 2);
        end
      end
      if (t == 9) begin
        checks++;
        if (gnt !== 2'b01 || rd_en !== 1'b0) begin
          errors++;
          $display("FAIL swap_done gnt=%b rd_en=%b expected 01 0", gnt, rd_en);
        end
      end
      if (t == 10) begin
        checks++;
        if ({overflow, frame_ready, wr_bank, rd_bank, gnt} !== 6'b0_1_0_1_00) begin
          errors++;
          $display("FAIL swap_same_cycle ov/fr/wb/rb/gnt=%b expected 010100",
                   {overflow, frame_ready, wr_bank, rd_bank, gnt});
        end
      end
    end
    rd_ready = 1'b0;
    repeat (2) tick_idle();
  endtask

  task automatic test_short_frame();
    write_beats(5, 1'b1, 0, 1'b0);
    write_beats(1, 1'b1, 0, 1'b0);
    write_beats(1, 1'b0, 1, 1'b0);
    checks++;
    if (short_frame !== 1'b1 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse sf=%b fr=%b expected 1 1", short_frame, frame_ready);
    end
    write_beats(1, 1'b0, 2, 1'b0);
    checks++;
    if (short_frame !== 1'b0) begin
      errors++;
      $display("FAIL short_width sf=%b expected 0", short_frame);
    end
    write_beats(5, 1'b0, 3, 1'b0);
    tick_idle();
    checks++;
    if ({overflow, wr_bank, rd_bank, frame_ready} !== 4'b1011) begin
      errors++;
      $display("FAIL short_then_full ov/wb/rb/fr=%b expected 1011", {overflow, wr_bank, rd_bank, frame_ready});
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    write_beats(N, 1'b1, 0, 1'b0);
    tick_idle();
    tick();
    req      = 2'b01;
    rd_ready = 1'b1;
    @(negedge sink_clk);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge sink_clk);
      checks++;
      if (rd_en !== 1'b1 || rd_addr !== 3'(k)) begin
        errors++;
        $display("FAIL midreset_pre rd_en=%b addr=%0d expected 1 %0d", rd_en, rd_addr, k);
      end
      if (k < 3) push_read(k);
    end
    #2;
    sink_reset = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({gnt, rd_en, frame_ready, rd_dvalid} !== 5'b00000) begin
      errors++;
      $display("FAIL midreset_async gnt=%b rd_en=%b fr=%b dv=%b expected all 0",
               gnt, rd_en, frame_ready, rd_dvalid);
    end
    req      = 2'b00;
    rd_ready = 1'b0;
    repeat (2) @(posedge sink_clk);
    #1 sink_reset = 1'b0;
    @(negedge sink_clk);
    checks++;
    if (wr_bank !== 1'b0 || rd_bank !== 1'b1 || frame_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release wb=%b rb=%b fr=%b expected 0 1 0", wr_bank, rd_bank, frame_ready);
    end
  endtask

  initial begin
    sink_reset = 1'b1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    req        = 2'b00;
    rd_ready   = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_abort();
    test_overflow_swap();
    test_short_frame();
    test_reset_mid_read();
    repeat (4) tick_idle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
